// File: rtl/cswap_serial_adder_pkg.sv
// Shared definitions for the bit-serial Fredkin adder: FSM states, width limits
// and the controlled-swap primitive used to build the full-adder cell.
package cswap_serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

    // Fredkin gate, selected rail only: passes p when c=0, q when c=1.
    // The complementary rail is garbage in every use here and is dropped.
    function automatic logic fswap(input logic c, input logic p, input logic q);
        return c ? q : p;
    endfunction

endpackage

// File: rtl/cswap_serial_adder_fa.sv
// One-bit full adder built from controlled swaps and constant ancillas only.
module fredkin_fa_bit
    import cswap_serial_adder_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic ny;
    logic p;
    logic np;

    // Ancillas 1/0 turn a swap into an inverter: c ? 0 : 1.
    assign ny = fswap(y, 1'b1, 1'b0);
    assign p  = fswap(x, y, ny);
    assign np = fswap(p, 1'b1, 1'b0);
    assign s  = fswap(ci, p, np);
    // Propagate picks the incoming carry; otherwise x == y and x is the carry.
    assign co = fswap(p, x, ci);

endmodule

// File: rtl/cswap_serial_adder.sv
// Bit-serial adder controller: captures operands, walks them LSB first through
// a single Fredkin full-adder cell and publishes {cout,sum} with a done pulse.
module cswap_serial_adder
    import cswap_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("cswap_serial_adder: WIDTH out of range 1..32");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_co;

    fredkin_fa_bit u_fa (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    generate
        if (WIDTH == 1) begin : g_acc1
            assign acc_next = fa_s;
        end else begin : g_accn
            assign acc_next = {fa_s, acc[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc   <= acc_next;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= acc_next;
                        cout  <= fa_co;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cswap_serial_adder.sv
// Directed + random checks of the serial adder against plain a+b+cin arithmetic.
module tb_cswap_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic       busy, done;
    logic [7:0] sum;
    logic       cout;

    logic       start2;
    logic [1:0] a2, b2;
    logic       cin2;
    logic       busy2, done2;
    logic [1:0] sum2;
    logic       cout2;

    int checks = 0;
    int errors = 0;
    int dpulses = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (done === 1'b1) dpulses++;
    end

    cswap_serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    cswap_serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Full transaction on the 8-bit instance; assumes it is idle on entry.
    task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        logic [8:0] exp;
        int lat;
        exp = {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = ~ta; b = ~tb; cin = ~tc;
        check({tag, "_busy"}, busy, 1'b1);
        wait_done8(lat);
        check({tag, "_lat"}, lat, 8);
        check({tag, "_sum"}, {cout, sum}, exp);
        @(posedge clk); #1;
        check({tag, "_idle"}, {busy, done}, 2'b00);
    endtask

    task automatic run2(input logic [1:0] ta, input logic [1:0] tb, input logic tc);
        int lat;
        @(negedge clk);
        a2 = ta; b2 = tb; cin2 = tc; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        lat = 0;
        while (done2 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w2_lat", lat, 2);
        check("w2_sum", {cout2, sum2}, {1'b0, ta} + {1'b0, tb} + {2'd0, tc});
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, t1, t2, p0;
        logic [7:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", {busy, done, cout, sum}, 11'd0);
        check("rst_state2", {busy2, done2, cout2, sum2}, 5'd0);
        @(negedge clk); rst_n = 1'b1;

        run8("basic", 8'h5A, 8'h3C, 1'b0);
        run8("chain1", 8'hFF, 8'h01, 1'b0);
        run8("chain2", 8'hFF, 8'hFF, 1'b1);

        // Start pulse while busy must be ignored.
        p0 = dpulses;
        @(negedge clk); a = 8'h10; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); @(negedge clk); a = 8'hAA; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done8(lat);
        check("busy_ign_lat", lat, 6);
        check("busy_ign_sum", {cout, sum}, 9'h011);
        repeat (12) @(posedge clk);
        #1;
        check("busy_ign_pulses", dpulses - p0, 1);

        // Reset mid-operation aborts with no done.
        @(negedge clk); a = 8'h77; b = 8'h11; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_state", {busy, done, cout, sum}, 11'd0);
        p0 = dpulses;
        @(negedge clk); rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("midrst_nodone", dpulses - p0, 0);
        run8("after_rst", 8'h02, 8'h03, 1'b0);

        // Start held high: re-accept on the first IDLE edge.
        @(negedge clk); a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 8'h80; b = 8'h80;
        wait_done8(lat);
        t1 = cyc;
        check("b2b_first", {cout, sum}, 9'h002);
        @(posedge clk); #1;
        wait_done8(lat);
        t2 = cyc;
        start = 1'b0;
        check("b2b_second", {cout, sum}, 9'h100);
        check("b2b_spacing", t2 - t1, 10);
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run8("rand", ra, rb, 1'($urandom));
        end

        for (int v = 0; v < 32; v++) begin
            logic [4:0] vv;
            vv = 5'(v);
            run2(vv[4:3], vv[2:1], vv[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
